// File: rtl/seg7_scan_driver.sv
// Six-digit multiplexed 7-segment driver for an hh.mm.ss clock.
// Snapshots the BCD digits once per frame and scans one digit per REFRESH_DIV cycles.
module seg7_scan_driver #(
  parameter int REFRESH_DIV  = 1000,
  parameter int BLANK_CYC    = 4,
  parameter int COMMON_ANODE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sec_ones,
  input  logic [3:0] sec_tens,
  input  logic [3:0] min_ones,
  input  logic [3:0] min_tens,
  input  logic [3:0] hr_ones,
  input  logic [3:0] hr_tens,
  input  logic       blank_lz,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_start
);

  localparam int            PW    = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] LAST  = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] BLANK = PW'(BLANK_CYC);
  localparam logic          INV   = (COMMON_ANODE != 0);

  logic [PW-1:0]   presc;
  logic [2:0]      idx;
  logic [5:0][3:0] snap;
  logic            load_pending;
  logic            cap_q;
  logic            tick, capture;
  logic [3:0]      cur;
  logic [5:0]      an_ah;
  logic [6:0]      seg_ah;
  logic            dp_ah;
  logic            in_blank, lz_hide;

  function automatic logic [6:0] dec7(input logic [3:0] v);
    case (v)
      4'd0:    dec7 = 7'b0111111;
      4'd1:    dec7 = 7'b0000110;
      4'd2:    dec7 = 7'b1011011;
      4'd3:    dec7 = 7'b1001111;
      4'd4:    dec7 = 7'b1100110;
      4'd5:    dec7 = 7'b1101101;
      4'd6:    dec7 = 7'b1111101;
      4'd7:    dec7 = 7'b0000111;
      4'd8:    dec7 = 7'b1111111;
      4'd9:    dec7 = 7'b1101111;
      default: dec7 = 7'b0000000;
    endcase
  endfunction

  assign tick    = (presc == LAST);
  assign capture = load_pending | (tick & (idx == 3'd5));

  always_comb begin
    cur = 4'd0;
    case (idx)
      3'd0:    cur = snap[0];
      3'd1:    cur = snap[1];
      3'd2:    cur = snap[2];
      3'd3:    cur = snap[3];
      3'd4:    cur = snap[4];
      3'd5:    cur = snap[5];
      default: cur = 4'd0;
    endcase
    in_blank = (presc < BLANK);
    // blank_lz is live so the user can toggle it without waiting a frame
    lz_hide  = blank_lz & (idx == 3'd5) & (snap[5] == 4'd0);
    an_ah    = (in_blank | lz_hide) ? 6'd0 : (6'd1 << idx);
    seg_ah   = dec7(cur);
    dp_ah    = ~in_blank & ((idx == 3'd2) | (idx == 3'd4));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc        <= '0;
      idx          <= 3'd0;
      snap         <= '0;
      load_pending <= 1'b1;
      cap_q        <= 1'b0;
      frame_start  <= 1'b0;
      an           <= {6{INV}};
      seg          <= {7{INV}};
      dp           <= INV;
    end else begin
      // frame_start rides one stage behind capture so it lines up with
      // index 0 reaching the registered outputs
      cap_q       <= capture;
      frame_start <= cap_q;
      if (capture) begin
        snap         <= {hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones};
        load_pending <= 1'b0;
      end
      if (load_pending) begin
        presc <= '0;
        idx   <= 3'd0;
      end else if (tick) begin
        presc <= '0;
        idx   <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
      end else begin
        presc <= presc + 1'b1;
      end
      an  <= an_ah  ^ {6{INV}};
      seg <= seg_ah ^ {7{INV}};
      dp  <= dp_ah  ^ INV;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench: common-anode and common-cathode instances share one stimulus stream.
module tb_seg7_scan_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens, hr_ones, hr_tens;
  logic       blank_lz;
  logic [5:0] an, an_cc;
  logic [6:0] seg, seg_cc;
  logic       dp, dp_cc, fs, fs_cc;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seg7_scan_driver #(.REFRESH_DIV(8), .BLANK_CYC(2), .COMMON_ANODE(1)) u_dut (
    .clk(clk), .rst(rst),
    .sec_ones(sec_ones), .sec_tens(sec_tens), .min_ones(min_ones),
    .min_tens(min_tens), .hr_ones(hr_ones), .hr_tens(hr_tens),
    .blank_lz(blank_lz), .an(an), .seg(seg), .dp(dp), .frame_start(fs)
  );

  seg7_scan_driver #(.REFRESH_DIV(8), .BLANK_CYC(2), .COMMON_ANODE(0)) u_dut_cc (
    .clk(clk), .rst(rst),
    .sec_ones(sec_ones), .sec_tens(sec_tens), .min_ones(min_ones),
    .min_tens(min_tens), .hr_ones(hr_ones), .hr_tens(hr_tens),
    .blank_lz(blank_lz), .an(an_cc), .seg(seg_cc), .dp(dp_cc), .frame_start(fs_cc)
  );

  function automatic logic [6:0] seg_exp(input logic [3:0] v);
    case (v)
      4'd0:    seg_exp = 7'b0111111;
      4'd1:    seg_exp = 7'b0000110;
      4'd2:    seg_exp = 7'b1011011;
      4'd3:    seg_exp = 7'b1001111;
      4'd4:    seg_exp = 7'b1100110;
      4'd5:    seg_exp = 7'b1101101;
      4'd6:    seg_exp = 7'b1111101;
      4'd7:    seg_exp = 7'b0000111;
      4'd8:    seg_exp = 7'b1111111;
      4'd9:    seg_exp = 7'b1101111;
      default: seg_exp = 7'b0000000;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_digits(input logic [23:0] d);
    {hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones} = d;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_an", {2'b00, an}, 8'h3F);
    chk("rst_seg", {1'b0, seg}, 8'h7F);
    chk("rst_dp", {7'd0, dp}, 8'h01);
    chk("rst_fs", {7'd0, fs}, 8'h00);
    chk("rst_an_cc", {2'b00, an_cc}, 8'h00);
    chk("rst_seg_cc", {1'b0, seg_cc}, 8'h00);
    chk("rst_dp_cc", {7'd0, dp_cc}, 8'h00);
  endtask

  // After rst release: frame_start must show up exactly 2 edges later.
  task automatic wait_frame();
    int n = 0;
    do begin
      step();
      n++;
    end while (!fs && n < 6);
    chk("fs_latency", 8'(n), 8'd2);
  endtask

  // Entered at slot 0 / cycle 0 of a frame; leaves at slot 0 / cycle 0 of the next.
  task automatic run_frame(input logic [23:0] d, input bit tear);
    logic [5:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    bit         hide;
    for (int s = 0; s < 6; s++) begin
      for (int c = 0; c < 8; c++) begin
        hide  = blank_lz && (s == 5) && (d[23:20] == 4'd0);
        e_an  = (c < 2 || hide) ? 6'd0 : (6'd1 << s);
        e_seg = seg_exp(d[s*4 +: 4]);
        e_dp  = (c >= 2) && (s == 2 || s == 4);
        chk("an", {2'b00, an}, {2'b00, ~e_an});
        chk("an_cc", {2'b00, an_cc}, {2'b00, e_an});
        if (c >= 2) begin
          chk("seg", {1'b0, seg}, {1'b0, ~e_seg});
          chk("seg_cc", {1'b0, seg_cc}, {1'b0, e_seg});
          chk("dp", {7'd0, dp}, {7'd0, ~e_dp});
          chk("dp_cc", {7'd0, dp_cc}, {7'd0, e_dp});
        end
        chk("frame_start", {7'd0, fs}, {7'd0, (s == 0 && c == 0)});
        if (tear && s == 3 && c == 0) set_digits(24'h235959);
        step();
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    blank_lz = 1'b0;
    set_digits(24'h123456);
    step();
    step();
    chk_reset_outputs();

    rst = 1'b1;
    wait_frame();
    // tearing: inputs change during index 3, frame still shows 12:34:56
    run_frame(24'h123456, 1'b1);
    set_digits(24'h07080A);
    blank_lz = 1'b1;
    run_frame(24'h235959, 1'b0);
    // hr_tens=0 hidden, sec_ones=A decodes blank
    run_frame(24'h07080A, 1'b0);
    blank_lz = 1'b0;
    run_frame(24'h07080A, 1'b0);

    // mid-slot asynchronous reset, checked with no clock edge in between
    for (int i = 0; i < 11; i++) step();
    rst = 1'b0;
    #2;
    chk_reset_outputs();
    step();
    step();
    chk_reset_outputs();
    rst = 1'b1;
    wait_frame();
    set_digits(24'h123456);
    run_frame(24'h07080A, 1'b0);
    run_frame(24'h123456, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
